// File: rtl/term_pkg.sv
// Shared constants and TX state encoding for the terminal byte path.
package term_pkg;

    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] ASCII_LF  = 8'h0A;
    localparam logic [7:0] ASCII_BS  = 8'h08;
    localparam logic [7:0] ASCII_DEL = 8'h7F;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StWait
    } tx_state_e;

endpackage

// File: rtl/term_fifo.sv
// Byte FIFO with push, pop and tail delete (unpush); occupancy kept in a count register.
module term_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [7:0]       i_data,
    input  logic             i_pop,
    input  logic             i_unpush,
    output logic [7:0]       o_data,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);

    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    // Push and unpush are never requested together by the line discipline.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_push) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            count_d  = count_d + CNT_W'(1);
        end
        if (i_unpush) begin
            wr_ptr_d = wr_ptr_q - ADDR_W'(1);
            count_d  = count_d - CNT_W'(1);
        end
        if (i_pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            count_d  = count_d - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

    assign o_data  = mem_q[rd_ptr_q];
    assign o_count = count_q;
    assign o_full  = (count_q == CNT_W'(DEPTH));
    assign o_empty = (count_q == '0);

endmodule

// File: rtl/term_linebuf.sv
// Terminal line buffer between UART RX and TX: line discipline, drop counter and TX handshake.
module term_linebuf
    import term_pkg::*;
#(
    parameter int unsigned DEPTH   = 16,
    parameter bit          CRLF_EN = 1'b1,
    parameter bit          BS_EN   = 1'b1,
    parameter int unsigned CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       i_byte,
    input  logic             i_byte_v,
    output logic [7:0]       o_byte,
    output logic             o_byte_v,
    input  logic             i_tx_active,
    input  logic             i_tx_done,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty,
    output logic [7:0]       o_drop_cnt
);

    tx_state_e  state_q, state_d;
    logic [7:0] byte_q, byte_d;
    logic       byte_v_q, byte_v_d;
    logic       lf_pend_q, lf_pend_d;
    logic [7:0] drop_q, drop_d;
    logic [8:0] drop_sum;
    logic [1:0] drops;

    logic       push, pop, unpush;
    logic [7:0] push_data, rd_data;
    logic       is_cr, is_bs;

    term_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_push   (push),
        .i_data   (push_data),
        .i_pop    (pop),
        .i_unpush (unpush),
        .o_data   (rd_data),
        .o_count  (o_count),
        .o_full   (o_full),
        .o_empty  (o_empty)
    );

    // Line discipline; a pending LF owns the write port for one cycle.
    always_comb begin
        is_cr     = CRLF_EN && (i_byte == ASCII_CR);
        is_bs     = BS_EN && ((i_byte == ASCII_BS) || (i_byte == ASCII_DEL));
        push      = 1'b0;
        unpush    = 1'b0;
        push_data = i_byte;
        drops     = 2'd0;
        lf_pend_d = lf_pend_q;
        if (lf_pend_q) begin
            push_data = ASCII_LF;
            lf_pend_d = 1'b0;
            if (o_full) begin
                drops = drops + 2'd1;
            end else begin
                push = 1'b1;
            end
            if (i_byte_v) begin
                drops = drops + 2'd1;
            end
        end else if (i_byte_v) begin
            // Never delete the entry being popped this cycle.
            if (is_bs && !o_empty && !(pop && (o_count == CNT_W'(1)))) begin
                unpush = 1'b1;
            end else if (o_full) begin
                drops = 2'd1;
            end else begin
                push = 1'b1;
            end
            if (is_cr) begin
                lf_pend_d = 1'b1;
            end
        end
        drop_sum = {1'b0, drop_q} + {7'd0, drops};
        drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    // The pop and output register load happen on the IDLE->LOAD edge, so the
    // strobe cycle already presents the byte.
    always_comb begin
        state_d  = state_q;
        byte_d   = byte_q;
        byte_v_d = 1'b0;
        pop      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!o_empty && !i_tx_active) begin
                    pop      = 1'b1;
                    byte_d   = rd_data;
                    byte_v_d = 1'b1;
                    state_d  = StLoad;
                end
            end
            StLoad: state_d = StWait;
            StWait: begin
                if (i_tx_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            byte_q    <= 8'h00;
            byte_v_q  <= 1'b0;
            lf_pend_q <= 1'b0;
            drop_q    <= 8'h00;
        end else begin
            state_q   <= state_d;
            byte_q    <= byte_d;
            byte_v_q  <= byte_v_d;
            lf_pend_q <= lf_pend_d;
            drop_q    <= drop_d;
        end
    end

    assign o_byte     = byte_q;
    assign o_byte_v   = byte_v_q;
    assign o_drop_cnt = drop_q;

endmodule

// File: tb/tb_term_linebuf.sv
// Self-checking bench for term_linebuf: vector table plus a transmit scoreboard.
module tb_term_linebuf;

    localparam int unsigned DEPTH  = 8;
    localparam int unsigned CNT_W  = 4;
    localparam int          TX_LEN = 10;

    logic             clk;
    logic             rst_n;
    logic [7:0]       i_byte;
    logic             i_byte_v;
    logic [7:0]       o_byte;
    logic             o_byte_v;
    logic             i_tx_active;
    logic             i_tx_done;
    logic [CNT_W-1:0] o_count;
    logic             o_full;
    logic             o_empty;
    logic [7:0]       o_drop_cnt;

    logic hold;
    logic tx_busy;
    logic tx_done;

    assign i_tx_active = hold | tx_busy;
    assign i_tx_done   = tx_done;

    term_linebuf #(
        .DEPTH   (DEPTH),
        .CRLF_EN (1'b1),
        .BS_EN   (1'b1),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_byte      (i_byte),
        .i_byte_v    (i_byte_v),
        .o_byte      (o_byte),
        .o_byte_v    (o_byte_v),
        .i_tx_active (i_tx_active),
        .i_tx_done   (i_tx_done),
        .o_count     (o_count),
        .o_full      (o_full),
        .o_empty     (o_empty),
        .o_drop_cnt  (o_drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;
    int n_out    = 0;
    int v_cyc    = 0;
    int done_cyc = 0;
    int last_gap = 0;

    logic [7:0] exp_q[$];
    bit         m_lf = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    // Reference line discipline: predicts transmitted bytes (valid while nothing is in flight).
    task automatic model_cycle(input bit v, input logic [7:0] b);
        if (m_lf) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(8'h0A);
            m_lf = 1'b0;
        end else if (v) begin
            if ((b == 8'h08 || b == 8'h7F) && exp_q.size() > 0) void'(exp_q.pop_back());
            else if (exp_q.size() < DEPTH) exp_q.push_back(b);
            if (b == 8'h0D) m_lf = 1'b1;
        end
    endtask

    task automatic drive(input bit v, input logic [7:0] b);
        i_byte_v = v;
        i_byte   = b;
        model_cycle(v, b);
        @(negedge clk);
        i_byte_v = 1'b0;
    endtask

    task automatic wait_drain(input int limit);
        int n = 0;
        while ((exp_q.size() != 0 || tx_busy || tx_done) && n < limit) begin
            drive(1'b0, 8'h00);
            n++;
        end
        chk("drain_timeout", int'(exp_q.size()), 0);
        drive(1'b0, 8'h00);
    endtask

    // Transmitter model and scoreboard consumer.
    initial begin : tx_model
        int left = 0;
        tx_busy = 1'b0;
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            tx_done = 1'b0;
            if (o_byte_v) begin
                chk("tx_idle_at_strobe", int'(tx_busy), 0);
                n_out++;
                v_cyc    = cyc;
                last_gap = cyc - done_cyc;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_byte: got 0x%02h with nothing expected", o_byte);
                end else begin
                    chk("tx_byte", int'(o_byte), int'(exp_q.pop_front()));
                end
                tx_busy = 1'b1;
                left    = TX_LEN;
            end else if (tx_busy) begin
                left--;
                if (left == 0) begin
                    tx_busy  = 1'b0;
                    tx_done  = 1'b1;
                    done_cyc = cyc;
                end
            end
        end
    end

    typedef struct {
        bit         v;
        logic [7:0] b;
        int         count;
        int         full;
        int         drop;
    } vec_t;

    vec_t vecs[17];

    initial begin : main
        int push_cyc;
        int out0;
        vecs[0]  = '{1'b1, 8'h61, 1, 0, 0};
        vecs[1]  = '{1'b1, 8'h62, 2, 0, 0};
        vecs[2]  = '{1'b1, 8'h63, 3, 0, 0};
        vecs[3]  = '{1'b1, 8'h08, 2, 0, 0};
        vecs[4]  = '{1'b1, 8'h7F, 1, 0, 0};
        vecs[5]  = '{1'b1, 8'h0D, 2, 0, 0};
        vecs[6]  = '{1'b0, 8'h00, 3, 0, 0};
        vecs[7]  = '{1'b1, 8'h0D, 4, 0, 0};
        vecs[8]  = '{1'b1, 8'h41, 5, 0, 1};
        vecs[9]  = '{1'b1, 8'h42, 6, 0, 1};
        vecs[10] = '{1'b1, 8'h43, 7, 0, 1};
        vecs[11] = '{1'b1, 8'h44, 8, 1, 1};
        vecs[12] = '{1'b1, 8'h45, 8, 1, 2};
        vecs[13] = '{1'b1, 8'h0D, 8, 1, 3};
        vecs[14] = '{1'b0, 8'h00, 8, 1, 4};
        vecs[15] = '{1'b1, 8'h08, 7, 0, 4};
        vecs[16] = '{1'b1, 8'h46, 8, 1, 4};

        rst_n    = 1'b0;
        hold     = 1'b0;
        i_byte   = 8'h00;
        i_byte_v = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_count", int'(o_count), 0);
        chk("rst_empty", int'(o_empty), 1);
        chk("rst_full", int'(o_full), 0);
        chk("rst_byte_v", int'(o_byte_v), 0);
        chk("rst_byte", int'(o_byte), 0);
        chk("rst_drop", int'(o_drop_cnt), 0);
        rst_n = 1'b1;
        drive(1'b0, 8'h00);

        // Single byte, latency and empty after done.
        push_cyc = cyc;
        drive(1'b1, 8'h41);
        wait_drain(100);
        chk("latency", v_cyc - push_cyc, 2);
        chk("empty_after_tx", int'(o_empty), 1);

        // CR expands to CR LF; LF strobe follows the CR frame's done.
        drive(1'b1, 8'h0D);
        wait_drain(200);
        chk("lf_after_cr_done", int'(last_gap >= 1), 1);

        // Table: transmitter held busy, occupancy/full/drop after each cycle.
        hold = 1'b1;
        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].v, vecs[i].b);
            chk($sformatf("vec%0d_count", i), int'(o_count), vecs[i].count);
            chk($sformatf("vec%0d_full", i), int'(o_full), vecs[i].full);
            chk($sformatf("vec%0d_empty", i), int'(o_empty), int'(vecs[i].count == 0));
            chk($sformatf("vec%0d_drop", i), int'(o_drop_cnt), vecs[i].drop);
        end
        hold = 1'b0;
        wait_drain(400);
        chk("table_drained_empty", int'(o_empty), 1);

        // DEL into empty FIFO goes out unchanged; byte on the LF cycle is dropped.
        drive(1'b1, 8'h7F);
        wait_drain(100);
        drive(1'b1, 8'h0D);
        drive(1'b1, 8'h55);
        chk("lf_cycle_drop", int'(o_drop_cnt), 5);
        wait_drain(200);

        // Reset during WAIT with 5 queued; later stray done must not emit.
        for (int i = 0; i < 6; i++) drive(1'b1, 8'h70 + 8'(i));
        chk("pre_reset_count", int'(o_count), 5);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_reset_count", int'(o_count), 0);
        chk("mid_reset_byte_v", int'(o_byte_v), 0);
        chk("mid_reset_empty", int'(o_empty), 1);
        chk("mid_reset_drop", int'(o_drop_cnt), 0);
        exp_q.delete();
        m_lf = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        out0  = n_out;
        repeat (25) drive(1'b0, 8'h00);
        chk("stray_done_no_output", n_out - out0, 0);
        chk("stray_done_empty", int'(o_empty), 1);

        // Overfill, drain in order, then one more byte across the pointer wrap.
        hold = 1'b1;
        for (int i = 0; i < DEPTH + 3; i++) drive(1'b1, 8'h30 + 8'(i));
        chk("full_flag", int'(o_full), 1);
        chk("full_count", int'(o_count), DEPTH);
        chk("full_drop", int'(o_drop_cnt), 3);
        out0 = n_out;
        hold = 1'b0;
        wait_drain(400);
        chk("drain_out_count", n_out - out0, DEPTH);
        chk("drain_empty", int'(o_empty), 1);
        drive(1'b1, 8'h5A);
        wait_drain(100);
        chk("wrap_out_count", n_out - out0, DEPTH + 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/term_linebuf.md
Name: term_linebuf

Overview:
Parametrised successor to the terminal byte buffer. It sits between the UART receiver and the UART transmitter in the terminal top level. Received bytes are queued in a DEPTH-entry FIFO and drained to the transmitter one byte per UART frame, using the transmitter's active/done handshake. Optional line-discipline modes: CR→CR LF expansion and backspace deletion of unsent bytes. Drops are counted.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 4
CRLF_EN, 1, 1 = received 0x0D is queued as 0x0D then 0x0A
BS_EN, 1, 1 = received 0x08/0x7F deletes the newest unsent entry
CNT_W, $clog2(DEPTH)+1, width of o_count

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
i_byte  in  8  received byte
i_byte_v  in  1  one-cycle strobe; i_byte is valid
o_byte  out  8  byte to the transmitter
o_byte_v  out  1  one-cycle strobe to start a transmit frame
i_tx_active  in  1  transmitter is busy
i_tx_done  in  1  one-cycle strobe; transmitter frame complete
o_count  out  CNT_W  current FIFO occupancy
o_full  out  1  o_count == DEPTH
o_empty  out  1  o_count == 0
o_drop_cnt  out  8  saturating count of dropped input bytes

Behaviour:
- Reset (asynchronous assert, synchronous release): FIFO pointers = 0; o_count = 0; o_empty = 1; o_full = 0; o_byte = 0x00; o_byte_v = 0; o_drop_cnt = 0; lf_pend = 0; FSM = IDLE.
- Push: i_byte_v with a normal byte and count < DEPTH → write at wr_ptr, wr_ptr++. When full, the byte is not written and o_drop_cnt increments, saturating at 255.
- CRLF_EN with byte 0x0D: push 0x0D this cycle and set lf_pend. Next cycle, push 0x0A and clear lf_pend. If the FIFO is full at either step, drop only that byte and increment o_drop_cnt. An i_byte_v arriving while lf_pend = 1 is dropped and counted.
- BS_EN with byte 0x08 or 0x7F:
  - If count > 0 and this is not a pop cycle with count == 1: wr_ptr--, count--. Nothing is queued.
  - Otherwise: push the byte unchanged, so the remote terminal still sees it.
- Pop and push in the same cycle are legal. Count is unchanged. The pop reads the entry at rd_ptr before the write.
- Pointers are ADDR_W = $clog2(DEPTH) bits and wrap modulo DEPTH. Full/empty come from the count register, not from pointer compare.
- TX FSM:
  - IDLE: if count > 0, i_tx_active = 0 and lf_pend has no pending write conflict → LOAD.
  - LOAD: o_byte <= mem[rd_ptr]; o_byte_v = 1 for exactly one cycle; rd_ptr++; count--. → WAIT.
  - WAIT: hold o_byte. On i_tx_done → IDLE.
- Latency: a byte pushed into an empty FIFO with an idle transmitter produces o_byte_v 2 cycles after i_byte_v (push cycle, then IDLE→LOAD).
- Throughput is limited by the transmitter. The next o_byte_v comes no earlier than 1 cycle after i_tx_done.
- o_byte_v never asserts while i_tx_active = 1 or while FSM = WAIT.
- i_tx_done while FSM ≠ WAIT is ignored.
- Reset asserted mid-frame: all state clears immediately. The transmitter finishes its frame independently, and the later i_tx_done is ignored.
- o_count, o_full and o_empty are registered and update on the cycle after the push/pop/delete.

Decomposition:
- Shared package term_pkg holds:
  - constants ASCII_CR = 8'h0D, ASCII_LF = 8'h0A, ASCII_BS = 8'h08, ASCII_DEL = 8'h7F;
  - the TX FSM state encoding (IDLE, LOAD, WAIT).
- One sub-module term_fifo: DEPTH×8 memory with push, pop and unpush (tail delete) ports, plus count/full/empty.
- term_linebuf holds the line-discipline decode, lf_pend, the drop counter and the TX FSM.

Test Plan:
- Reset, then push 0x41 with i_tx_active = 0 → o_byte_v pulses 2 cycles later with o_byte = 0x41. Return i_tx_done → o_empty = 1.
- Push 0x0D (CRLF_EN = 1) → transmitted sequence is 0x0D then 0x0A. o_byte_v for the second byte comes only after i_tx_done of the first.
- Hold i_tx_active = 1 and push 0x61, 0x62, 0x63, 0x08 → o_count = 2. After release, transmitted bytes are 0x61, 0x62 only.
- Hold the transmitter busy and push DEPTH+3 bytes → o_full = 1, o_drop_cnt = 3. Drain → exactly DEPTH bytes out, in order. Push one more → the pointer wrap is correct.
- Push 0x7F with the FIFO empty → 0x7F is transmitted unchanged. Push 0x0D, then another byte on the lf_pend cycle → that byte is dropped and o_drop_cnt++.
- Assert rst_n = 0 while in WAIT with 5 bytes queued → o_count = 0 and o_byte_v = 0 immediately. The following stray i_tx_done produces no output.
